// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and defaults for the unified memory arbiter.
// Line/address widths, starvation limit and FSM state encoding.
package unified_mem_arbiter_pkg;

  localparam int DEF_ADDR_W   = 14;
  localparam int DEF_LINE_W   = 64;
  localparam int DEF_STARVE_N = 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_I_RD = 3'd1,
    ST_D_RD = 3'd2,
    ST_D_WR = 3'd3,
    ST_RESP = 3'd4
  } arb_state_e;

endpackage

// File: rtl/unified_mem_arbiter.sv
// Serialises I-fill, D-fill and D-evict onto one memory handshake.
// Ports: i_* I-cache, d_* D-cache, mem_* main memory, idle to hierarchy.
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int LINE_W   = DEF_LINE_W,
  parameter int STARVE_N = DEF_STARVE_N
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_rdy,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_rdy,
  output logic [LINE_W-1:0] d_rdata,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_rdy,
  output logic              idle
);

  localparam int SC_W = $clog2(STARVE_N + 1);
  localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_N);

  arb_state_e        state_q;
  logic [SC_W-1:0]   starve_q;
  logic [SC_W-1:0]   starve_d;
  logic              mem_re_q;
  logic              mem_we_q;
  logic              i_rdy_q;
  logic              d_rdy_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [LINE_W-1:0] mem_wdata_q;
  logic [LINE_W-1:0] i_rdata_q;
  logic [LINE_W-1:0] d_rdata_q;
  logic              d_win;

  // D wins ties until it has taken STARVE_N grants in a row
  // over a waiting I request.
  assign d_win = d_req & ((starve_q < STARVE_MAX) | ~i_req);

  always_comb begin
    starve_d = '0;
    if (i_req) begin
      starve_d = (starve_q == STARVE_MAX) ?
                 starve_q : starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      starve_q    <= '0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      i_rdy_q     <= 1'b0;
      d_rdy_q     <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      i_rdy_q <= 1'b0;
      d_rdy_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (d_win) begin
            starve_q   <= starve_d;
            mem_addr_q <= d_addr;
            if (d_we) begin
              mem_wdata_q <= d_wdata;
              mem_we_q    <= 1'b1;
              state_q     <= ST_D_WR;
            end else begin
              mem_re_q <= 1'b1;
              state_q  <= ST_D_RD;
            end
          end else if (i_req) begin
            starve_q   <= '0;
            mem_addr_q <= i_addr;
            mem_re_q   <= 1'b1;
            state_q    <= ST_I_RD;
          end
        end
        ST_I_RD: begin
          if (mem_rdy) begin
            i_rdata_q <= mem_rdata;
            mem_re_q  <= 1'b0;
            i_rdy_q   <= 1'b1;
            state_q   <= ST_RESP;
          end
        end
        ST_D_RD: begin
          if (mem_rdy) begin
            d_rdata_q <= mem_rdata;
            mem_re_q  <= 1'b0;
            d_rdy_q   <= 1'b1;
            state_q   <= ST_RESP;
          end
        end
        ST_D_WR: begin
          if (mem_rdy) begin
            mem_we_q <= 1'b0;
            d_rdy_q  <= 1'b1;
            state_q  <= ST_RESP;
          end
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign i_rdy     = i_rdy_q;
  assign d_rdy     = d_rdy_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign idle      = (state_q == ST_IDLE) & ~i_req & ~d_req;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: directed cases plus random traffic
// against a transaction-level reference model and a memory responder.
module tb_unified_mem_arbiter;

  localparam int SN = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        i_req = 1'b0;
  logic [13:0] i_addr = '0;
  logic        i_rdy;
  logic [63:0] i_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [13:0] d_addr = '0;
  logic [63:0] d_wdata = '0;
  logic        d_rdy;
  logic [63:0] d_rdata;
  logic        mem_re;
  logic        mem_we;
  logic [13:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata = '0;
  logic        mem_rdy = 1'b0;
  logic        idle;

  always #5 clk = ~clk;

  unified_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr),
    .i_rdy(i_rdy), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdy(d_rdy), .d_rdata(d_rdata),
    .mem_re(mem_re), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rdy(mem_rdy),
    .idle(idle)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] seed_word(input logic [13:0] a);
    if (a == 14'h0010) return 64'h0123_4567_89AB_CDEF;
    return {16'hA5A5 ^ {2'b0, a}, {2'b0, a} * 16'd3,
            16'h5A5A, {2'b0, a}};
  endfunction

  // Memory seen by the responder (written from DUT strobes).
  logic [63:0] bmem [0:16383];
  bit          bmem_wr [0:16383];
  function automatic logic [63:0] bmem_rd(input logic [13:0] a);
    return bmem_wr[a] ? bmem[a] : seed_word(a);
  endfunction

  // Reference model: one transaction at a time, grant by rule.
  typedef enum logic [1:0] {P_FREE, P_MEM, P_RESP} ph_e;
  ph_e         ph;
  logic        t_dn;
  logic        t_we;
  logic [13:0] t_addr;
  logic [63:0] t_wdata;
  logic [63:0] exp_i_rdata;
  logic [63:0] exp_d_rdata;
  int          starve;
  logic [63:0] mref [0:16383];
  bit          mref_wr [0:16383];

  function automatic logic [63:0] mref_rd(input logic [13:0] a);
    return mref_wr[a] ? mref[a] : seed_word(a);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph          <= P_FREE;
      starve      <= 0;
      t_dn        <= 1'b0;
      t_we        <= 1'b0;
      t_addr      <= '0;
      t_wdata     <= '0;
      exp_i_rdata <= '0;
      exp_d_rdata <= '0;
    end else begin
      case (ph)
        P_FREE: begin
          if (d_req && (starve < SN || !i_req)) begin
            ph      <= P_MEM;
            t_dn    <= 1'b1;
            t_we    <= d_we;
            t_addr  <= d_addr;
            t_wdata <= d_wdata;
            starve  <= i_req ? ((starve >= SN) ? SN : starve + 1) : 0;
          end else if (i_req) begin
            ph     <= P_MEM;
            t_dn   <= 1'b0;
            t_we   <= 1'b0;
            t_addr <= i_addr;
            starve <= 0;
          end
        end
        P_MEM: begin
          if (mem_rdy) begin
            ph <= P_RESP;
            if (t_we) begin
              mref[t_addr]    <= t_wdata;
              mref_wr[t_addr] <= 1'b1;
            end else if (t_dn) begin
              exp_d_rdata <= mref_rd(t_addr);
            end else begin
              exp_i_rdata <= mref_rd(t_addr);
            end
          end
        end
        default: ph <= P_FREE;
      endcase
    end
  end

  int          cyc = 0;
  int          i_pulses = 0;
  int          d_pulses = 0;
  int          last_i_rdy_cyc = 0;
  int          last_d_rdy_cyc = 0;
  logic        prev_strobe = 1'b0;
  logic        g_we [$];
  logic [13:0] g_addr [$];
  int          g_cyc [$];

  bit          rsp_busy = 0;
  logic        rsp_we = 1'b0;
  logic [13:0] rsp_addr = '0;
  logic [63:0] rsp_wdata = '0;
  int          rsp_cnt = 0;
  int          fixed_lat = -1;
  bit          spur_en = 0;
  bit          rand_mode = 0;
  bit          d_hold = 0;

  function automatic logic [13:0] rnd_addr();
    return 14'($urandom_range(0, 31));
  endfunction

  task automatic check_outputs();
    bit in_mem;
    in_mem = (ph == P_MEM);
    chk("mem_re", 64'(mem_re), 64'(in_mem && !t_we));
    chk("mem_we", 64'(mem_we), 64'(in_mem && t_we));
    if (in_mem) chk("mem_addr", 64'(mem_addr), 64'(t_addr));
    if (in_mem && t_we) chk("mem_wdata", mem_wdata, t_wdata);
    chk("i_rdy", 64'(i_rdy), 64'(ph == P_RESP && !t_dn));
    chk("d_rdy", 64'(d_rdy), 64'(ph == P_RESP && t_dn));
    chk("i_rdata", i_rdata, exp_i_rdata);
    chk("d_rdata", d_rdata, exp_d_rdata);
    chk("idle", 64'(idle),
        64'(ph == P_FREE && !i_req && !d_req));
  endtask

  task automatic cycle();
    logic strobe;
    bit   i_off;
    bit   d_off;
    @(negedge clk);
    cyc++;
    check_outputs();
    if (i_rdy) begin i_pulses++; last_i_rdy_cyc = cyc; end
    if (d_rdy) begin d_pulses++; last_d_rdy_cyc = cyc; end
    strobe = mem_re | mem_we;
    if (strobe && !prev_strobe && rst_n) begin
      g_we.push_back(mem_we);
      g_addr.push_back(mem_addr);
      g_cyc.push_back(cyc);
    end
    prev_strobe = strobe;
    // memory responder
    if (!rst_n) begin
      mem_rdy  = 1'b0;
      rsp_busy = 0;
    end else if (mem_rdy) begin
      mem_rdy = 1'b0;
      if (rsp_busy) begin
        if (rsp_we) begin
          bmem[rsp_addr]    = rsp_wdata;
          bmem_wr[rsp_addr] = 1'b1;
        end
        rsp_busy = 0;
      end
    end else begin
      if (strobe && !rsp_busy) begin
        rsp_busy  = 1;
        rsp_we    = mem_we;
        rsp_addr  = mem_addr;
        rsp_wdata = mem_wdata;
        rsp_cnt   = (fixed_lat >= 0) ? fixed_lat
                                     : int'($urandom_range(0, 3));
      end
      if (rsp_busy) begin
        if (rsp_cnt == 0) begin
          mem_rdy   = 1'b1;
          mem_rdata = rsp_we ? {$urandom, $urandom}
                             : bmem_rd(rsp_addr);
        end else begin
          rsp_cnt--;
        end
      end else if (spur_en && $urandom_range(0, 7) == 0) begin
        mem_rdy   = 1'b1;
        mem_rdata = {$urandom, $urandom};
      end
    end
    // requesters drop on their rdy
    i_off = 0;
    d_off = 0;
    if (i_rdy) begin i_req = 1'b0; i_off = 1; end
    if (d_rdy && !d_hold) begin d_req = 1'b0; d_off = 1; end
    if (rand_mode) begin
      if (!i_req) begin
        if (!i_off && $urandom_range(0, 1) == 1) begin
          i_req  = 1'b1;
          i_addr = rnd_addr();
        end
      end else if ($urandom_range(0, 3) == 0) begin
        i_addr = rnd_addr();
      end
      if (!d_req) begin
        if (!d_off && $urandom_range(0, 3) != 0) begin
          d_req   = 1'b1;
          d_we    = 1'($urandom_range(0, 1));
          d_addr  = rnd_addr();
          d_wdata = {$urandom, $urandom};
        end
      end else if ($urandom_range(0, 3) == 0) begin
        d_addr  = rnd_addr();
        d_wdata = {$urandom, $urandom};
      end
    end
  endtask

  task automatic run_until_quiet(input int budget, input string tag);
    int n;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!(ph == P_FREE && !i_req && !d_req) && n < budget);
    chk(tag, 64'(n < budget), 64'd1);
  endtask

  int p0;
  int n;

  initial begin
    #1 rst_n = 1'b0;
    // 1: reset with i_req held
    i_req  = 1'b1;
    i_addr = 14'h0033;
    repeat (3) cycle();
    chk("t1_idle", 64'(idle), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_wdata", mem_wdata, 64'd0);
    chk("rst_irdata", i_rdata, 64'd0);
    rst_n = 1'b1;
    cycle();
    chk("t1_re", 64'(mem_re), 64'd1);
    chk("t1_addr", 64'(mem_addr), 64'h0033);
    run_until_quiet(40, "t1_done");

    // 2: I fill, memory answers in cycle 4
    cycle();
    fixed_lat = 3;
    g_cyc.delete(); g_we.delete(); g_addr.delete();
    p0 = d_pulses;
    n = i_pulses;
    i_req  = 1'b1;
    i_addr = 14'h0010;
    run_until_quiet(40, "t2_done");
    chk("t2_i_rdata", i_rdata, 64'h0123_4567_89AB_CDEF);
    chk("t2_ipulse", 64'(i_pulses - n), 64'd1);
    chk("t2_no_drdy", 64'(d_pulses - p0), 64'd0);
    if (g_cyc.size() > 0)
      chk("t2_lat", 64'(last_i_rdy_cyc - g_cyc[0]), 64'd4);
    else
      chk("t2_strobe", 64'd0, 64'd1);

    // 3: simultaneous I read and D evict
    cycle();
    fixed_lat = -1;
    g_cyc.delete(); g_we.delete(); g_addr.delete();
    i_req   = 1'b1;
    i_addr  = 14'h0044;
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 14'h0200;
    d_wdata = 64'hDEAD_BEEF_CAFE_F00D;
    run_until_quiet(60, "t3_done");
    chk("t3_ngrant", 64'(g_we.size()), 64'd2);
    if (g_we.size() >= 2) begin
      chk("t3_g0_we", 64'(g_we[0]), 64'd1);
      chk("t3_g0_addr", 64'(g_addr[0]), 64'h0200);
      chk("t3_g1_we", 64'(g_we[1]), 64'd0);
      chk("t3_g1_addr", 64'(g_addr[1]), 64'h0044);
      chk("t3_gap", 64'(g_cyc[1] - last_d_rdy_cyc), 64'd2);
    end
    chk("t3_wdata", bmem_rd(14'h0200), 64'hDEAD_BEEF_CAFE_F00D);

    // 4: D held across back-to-back fills with I waiting
    cycle();
    fixed_lat = 1;
    g_cyc.delete(); g_we.delete(); g_addr.delete();
    d_hold = 1;
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 14'h0100;
    i_req  = 1'b1;
    i_addr = 14'h0050;
    n = 0;
    while (g_we.size() < 4 && n < 80) begin
      cycle();
      n++;
    end
    chk("t4_budget", 64'(n < 80), 64'd1);
    d_hold = 0;
    d_req  = 1'b0;
    run_until_quiet(40, "t4_done");
    if (g_addr.size() >= 4) begin
      chk("t4_g0", 64'(g_addr[0]), 64'h0100);
      chk("t4_g1", 64'(g_addr[1]), 64'h0100);
      chk("t4_g2", 64'(g_addr[2]), 64'h0050);
      chk("t4_g3", 64'(g_addr[3]), 64'h0100);
    end

    // 5: spurious mem_rdy in idle, then D drops mid-read
    cycle();
    p0 = i_pulses + d_pulses;
    mem_rdy   = 1'b1;
    mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    cycle();
    cycle();
    chk("t5_spur_rdy", 64'(i_pulses + d_pulses - p0), 64'd0);
    chk("t5_idle", 64'(idle), 64'd1);
    fixed_lat = 3;
    p0 = d_pulses;
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 14'h00AA;
    cycle();
    cycle();
    d_req = 1'b0;
    run_until_quiet(40, "t5_done");
    chk("t5_dpulse", 64'(d_pulses - p0), 64'd1);
    chk("t5_d_rdata", d_rdata, bmem_rd(14'h00AA));

    // 6: reset during an evict
    cycle();
    fixed_lat = 5;
    p0 = d_pulses;
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 14'h0300;
    d_wdata = 64'h1111_2222_3333_4444;
    cycle();
    cycle();
    chk("t6_we_pre", 64'(mem_we), 64'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_we", 64'(mem_we), 64'd0);
    chk("t6_rdy", 64'(d_rdy), 64'd0);
    chk("t6_addr", 64'(mem_addr), 64'd0);
    d_req = 1'b0;
    #1;
    chk("t6_idle", 64'(idle), 64'd1);
    cycle();
    rst_n = 1'b1;
    repeat (6) cycle();
    chk("t6_no_drdy", 64'(d_pulses - p0), 64'd0);
    chk("t6_nowrite", bmem_rd(14'h0300), seed_word(14'h0300));

    // random traffic
    fixed_lat = -1;
    spur_en   = 1;
    rand_mode = 1;
    repeat (3000) cycle();
    rand_mode = 0;
    spur_en   = 0;
    run_until_quiet(100, "rand_done");

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
